// File: rtl/reset_domain_sequencer.sv
// reset_domain_sequencer
// Releases NUM_DOMAINS fabric reset domains in index order once the PLL is
// locked. It then serves per-domain soft-reset requests one at a time, each
// with a quiesce handshake that has a timeout. If PLL lock is lost, every
// domain is dropped back into reset and the release sequence runs again.
//
// Ports:
//   CLK             system clock
//   FABRIC_RESET_N  async active-low reset (deassertion already synchronous)
//   PLL_LOCK        async lock indication, 2-flop synchronised to lock_s
//   SOFT_RST_REQ    per-domain level soft-reset request
//   QUIESCE_ACK     per-domain "idle, safe to reset" acknowledge
//   DOMAIN_RESET_N  per-domain active-low reset, registered
//   QUIESCE_REQ     per-domain drain request, registered
//   SOFT_RST_ACK    per-domain one-cycle completion pulse
//   SEQ_DONE        all domains released and block idle in RUN
//   TIMEOUT_ERR     sticky quiesce-timeout flag
module reset_domain_sequencer #(
  parameter int NUM_DOMAINS     = 4,
  parameter int CNT_W           = 16,
  parameter int INIT_DELAY      = 16,
  parameter int STAGE_DELAY     = 8,
  parameter int HOLD_CYCLES     = 4,
  parameter int QUIESCE_TIMEOUT = 32
) (
  input  logic                   CLK,
  input  logic                   FABRIC_RESET_N,
  input  logic                   PLL_LOCK,
  input  logic [NUM_DOMAINS-1:0] SOFT_RST_REQ,
  input  logic [NUM_DOMAINS-1:0] QUIESCE_ACK,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N,
  output logic [NUM_DOMAINS-1:0] QUIESCE_REQ,
  output logic [NUM_DOMAINS-1:0] SOFT_RST_ACK,
  output logic                   SEQ_DONE,
  output logic                   TIMEOUT_ERR
);

  // A programmed delay of zero behaves like a delay of one cycle.
  localparam int INIT_EFF  = (INIT_DELAY      == 0) ? 1 : INIT_DELAY;
  localparam int STAGE_EFF = (STAGE_DELAY     == 0) ? 1 : STAGE_DELAY;
  localparam int HOLD_EFF  = (HOLD_CYCLES     == 0) ? 1 : HOLD_CYCLES;
  localparam int QTO_EFF   = (QUIESCE_TIMEOUT == 0) ? 1 : QUIESCE_TIMEOUT;
  localparam int IDX_W     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  // Reject parameter sets that the counter or output vectors cannot hold.
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_domains
    $error("reset_domain_sequencer: NUM_DOMAINS must be 1..8");
  end
  if (INIT_DELAY > (1 << CNT_W) - 1 || STAGE_DELAY > (1 << CNT_W) - 1 ||
      HOLD_CYCLES > (1 << CNT_W) - 1 || QUIESCE_TIMEOUT > (1 << CNT_W) - 1) begin : g_bad_delay
    $error("reset_domain_sequencer: a delay parameter exceeds 2**CNT_W-1");
  end

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_INIT_WAIT,
    ST_RELEASE,
    ST_RUN,
    ST_QUIESCE,
    ST_HOLD
  } state_t;

  state_t                 state_q, state_n;
  logic [CNT_W-1:0]       cnt_q, cnt_n, cnt_dec;
  logic [IDX_W-1:0]       idx_q, idx_n;
  logic [IDX_W-1:0]       gnt_q, gnt_n, req_idx;
  logic [NUM_DOMAINS-1:0] drn_q, drn_n;
  logic [NUM_DOMAINS-1:0] qreq_q, qreq_n;
  logic [NUM_DOMAINS-1:0] ack_q, ack_n;
  logic                   done_q, done_n;
  logic                   terr_q, terr_n;
  logic                   lock_meta, lock_s;
  logic                   req_any, terminal;

  // Two-flop synchroniser for the asynchronous PLL lock input.
  always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
    if (!FABRIC_RESET_N) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_s    <= lock_meta;
    end
  end

  // Fixed-priority arbitration: the lowest requesting index wins.
  always_comb begin
    req_any = |SOFT_RST_REQ;
    req_idx = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (SOFT_RST_REQ[i]) req_idx = IDX_W'(i);
    end
  end

  // The counter is reloaded on every state entry and stops at zero. A state's
  // exit fires on the edge that sees a count of one, so a load of D exits on
  // the D-th edge after entry.
  assign terminal = (cnt_q <= CNT_W'(1));
  assign cnt_dec  = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);

  // Next-state and next-output logic. All outputs are registered, so every
  // output change below becomes visible on the edge that takes the transition.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    gnt_n   = gnt_q;
    drn_n   = drn_q;
    qreq_n  = qreq_q;
    ack_n   = '0;
    done_n  = 1'b0;
    terr_n  = terr_q;

    unique case (state_q)
      ST_WAIT_LOCK: begin
        drn_n  = '0;
        qreq_n = '0;
        if (lock_s) begin
          state_n = ST_INIT_WAIT;
          cnt_n   = CNT_W'(INIT_EFF);
        end
      end
      ST_INIT_WAIT: begin
        if (terminal) begin
          drn_n[0] = 1'b1;
          if (NUM_DOMAINS == 1) begin
            state_n = ST_RUN;
          end else begin
            state_n = ST_RELEASE;
            idx_n   = IDX_W'(1);
            cnt_n   = CNT_W'(STAGE_EFF);
          end
        end else begin
          cnt_n = cnt_dec;
        end
      end
      ST_RELEASE: begin
        if (terminal) begin
          drn_n[idx_q] = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_n = ST_RUN;
          end else begin
            idx_n = idx_q + IDX_W'(1);
            cnt_n = CNT_W'(STAGE_EFF);
          end
        end else begin
          cnt_n = cnt_dec;
        end
      end
      ST_RUN: begin
        // SEQ_DONE is held low on a grant edge so it never glitches high.
        if (req_any) begin
          state_n         = ST_QUIESCE;
          gnt_n           = req_idx;
          qreq_n[req_idx] = 1'b1;
          cnt_n           = CNT_W'(QTO_EFF);
        end else begin
          done_n = 1'b1;
        end
      end
      ST_QUIESCE: begin
        // An acknowledge arriving together with the timeout still counts as
        // a clean handshake.
        if (QUIESCE_ACK[gnt_q] || terminal) begin
          if (!QUIESCE_ACK[gnt_q]) terr_n = 1'b1;
          state_n       = ST_HOLD;
          qreq_n[gnt_q] = 1'b0;
          drn_n[gnt_q]  = 1'b0;
          cnt_n         = CNT_W'(HOLD_EFF);
        end else begin
          cnt_n = cnt_dec;
        end
      end
      ST_HOLD: begin
        if (terminal) begin
          state_n      = ST_RUN;
          drn_n[gnt_q] = 1'b1;
          ack_n[gnt_q] = 1'b1;
        end else begin
          cnt_n = cnt_dec;
        end
      end
      default: begin
        state_n = ST_WAIT_LOCK;
        drn_n   = '0;
        qreq_n  = '0;
      end
    endcase

    // Lock loss overrides everything: drop all domains with no handshake and
    // abandon any soft reset without acknowledging it.
    if (state_q != ST_WAIT_LOCK && !lock_s) begin
      state_n = ST_WAIT_LOCK;
      drn_n   = '0;
      qreq_n  = '0;
      ack_n   = '0;
      done_n  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
    if (!FABRIC_RESET_N) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      drn_q   <= '0;
      qreq_q  <= '0;
      ack_q   <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      gnt_q   <= gnt_n;
      drn_q   <= drn_n;
      qreq_q  <= qreq_n;
      ack_q   <= ack_n;
      done_q  <= done_n;
      terr_q  <= terr_n;
    end
  end

  assign DOMAIN_RESET_N = drn_q;
  assign QUIESCE_REQ    = qreq_q;
  assign SOFT_RST_ACK   = ack_q;
  assign SEQ_DONE       = done_q;
  assign TIMEOUT_ERR    = terr_q;

endmodule

// File: doc/reset_domain_sequencer.md
Name: reset_domain_sequencer

Overview:
- Sequences reset release and reassertion for NUM_DOMAINS downstream fabric domains, downstream of the CORERESET_PF fabric reset output.
- Releases domains in fixed order (index 0 first) after PLL lock with programmed delays.
- On PLL lock loss, re-runs the full sequence.
- Arbitrates per-domain soft-reset requests from the MSS/software, with a quiesce handshake and timeout.

Parameters:
- NUM_DOMAINS, 4, number of reset domains (1..8).
- CNT_W, 16, width of the internal delay counter.
- INIT_DELAY, 16, cycles from sequence start to release of domain 0 (0 treated as 1).
- STAGE_DELAY, 8, cycles between successive domain releases (0 treated as 1).
- HOLD_CYCLES, 4, cycles a soft-reset domain is held in reset (0 treated as 1).
- QUIESCE_TIMEOUT, 32, cycles to wait for QUIESCE_ACK before forcing reset (0 treated as 1).

Ports:
- CLK  in  1  system clock.
- FABRIC_RESET_N  in  1  asynchronous active-low reset; assertion is async, deassertion is assumed already synchronised to CLK.
- PLL_LOCK  in  1  asynchronous; 2-flop synchronised internally (lock_s).
- SOFT_RST_REQ  in  NUM_DOMAINS  level request per domain, synchronous to CLK.
- QUIESCE_ACK  in  NUM_DOMAINS  domain is idle and safe to reset, synchronous to CLK.
- DOMAIN_RESET_N  out  NUM_DOMAINS  active-low domain resets, registered.
- QUIESCE_REQ  out  NUM_DOMAINS  request domain to drain, registered.
- SOFT_RST_ACK  out  NUM_DOMAINS  1-cycle completion pulse.
- SEQ_DONE  out  1  all domains released, block in RUN.
- TIMEOUT_ERR  out  1  sticky: a quiesce timeout occurred.

Behaviour:
- Clock and reset: one clock CLK. FABRIC_RESET_N is asynchronous, active-low.

Reset state (FABRIC_RESET_N low, asynchronous):
- DOMAIN_RESET_N = 0.
- QUIESCE_REQ = 0.
- SOFT_RST_ACK = 0.
- SEQ_DONE = 0.
- TIMEOUT_ERR = 0.
- Synchroniser cleared.
- State = WAIT_LOCK.

States and transitions:
- WAIT_LOCK: all DOMAIN_RESET_N = 0.
  - Go to INIT_WAIT on the first edge with lock_s = 1; load counter with INIT_DELAY.
- INIT_WAIT: counter decrements each cycle.
  - At terminal count, DOMAIN_RESET_N[0] rises on exactly the INIT_DELAY-th edge after entry.
  - Go to RELEASE; idx = 1; load STAGE_DELAY.
- RELEASE: DOMAIN_RESET_N[idx] rises STAGE_DELAY edges after DOMAIN_RESET_N[idx-1].
  - After the last domain is released, go to RUN next edge.
  - SEQ_DONE = 1 one cycle after the last release.
  - NUM_DOMAINS = 1 skips RELEASE.
- RUN: SEQ_DONE = 1.
  - If any SOFT_RST_REQ bit is high, grant the lowest index g (fixed priority) and go to QUIESCE; SEQ_DONE drops the same edge.
- QUIESCE: QUIESCE_REQ[g] = 1; counter loaded with QUIESCE_TIMEOUT.
  - Go to HOLD when QUIESCE_ACK[g] = 1.
  - At timeout, go to HOLD and set TIMEOUT_ERR.
  - On entry to HOLD: DOMAIN_RESET_N[g] = 0 and QUIESCE_REQ[g] = 0.
- HOLD: DOMAIN_RESET_N[g] held low for exactly HOLD_CYCLES cycles, then driven to 1.
  - SOFT_RST_ACK[g] pulses for 1 cycle coincident with the release.
  - Go to RUN; SEQ_DONE returns to 1 the next cycle.

PLL lock loss:
- lock_s falling in any state except WAIT_LOCK forces all DOMAIN_RESET_N = 0, QUIESCE_REQ = 0, SEQ_DONE = 0 on the next edge.
- Any in-progress soft reset is aborted without an ACK.
- State returns to WAIT_LOCK.
- No quiesce handshake on lock loss.

Other rules:
- Only one soft reset is in progress at a time.
- A request that deasserts before grant is ignored.
- Requests held through HOLD are re-granted after returning to RUN (fresh arbitration).
- Requests seen outside RUN are not latched.
- Soft reset affects only domain g; other domains stay released.
- QUIESCE_ACK on non-granted domains is ignored.
- QUIESCE_ACK already high on entry to QUIESCE: the block goes to HOLD after the minimum 1 cycle in QUIESCE.
- TIMEOUT_ERR clears only on FABRIC_RESET_N.
- Counters saturate at 0, never wrap.
- Delays above 2^CNT_W-1 are illegal; this is checked by an elaboration-time assertion.

Test Plan (defaults; t0 = first edge with lock_s = 1 after FABRIC_RESET_N deasserts):
- Power-up: FABRIC_RESET_N low for 5 cycles, then high, with PLL_LOCK high -> DOMAIN_RESET_N[0..3] rise at t0+16, +24, +32, +40; SEQ_DONE = 1 at t0+41; all outputs 0 during reset.
- Soft reset, acked: in RUN, SOFT_RST_REQ = 4'b0100, QUIESCE_ACK[2] raised 5 cycles after QUIESCE_REQ[2] -> DOMAIN_RESET_N[2] low for 4 cycles; SOFT_RST_ACK[2] pulses once; domains 0, 1, 3 stay 1; TIMEOUT_ERR = 0.
- Timeout: SOFT_RST_REQ[1] high, QUIESCE_ACK tied 0 -> QUIESCE_REQ[1] high for 32 cycles; then DOMAIN_RESET_N[1] low for 4 cycles; TIMEOUT_ERR = 1 and stays 1 until FABRIC_RESET_N.
- Arbitration: SOFT_RST_REQ = 4'b1010 held, ACKs tied 1 -> domain 1 serviced first, then domain 3 on return to RUN; SOFT_RST_ACK pulses in order 1, then 3.
- Lock loss during HOLD of domain 0: PLL_LOCK low for 10 cycles -> all DOMAIN_RESET_N = 0 within 3 edges; no SOFT_RST_ACK; after lock returns, full release sequence re-runs with the same offsets as power-up.
- Async reset mid-RELEASE: FABRIC_RESET_N pulsed low for 1 ns between edges -> all outputs 0 immediately; sequence restarts from WAIT_LOCK.
